// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, hazard/redirect inputs and IF/ID outputs.
// Signal suffixes are from the fetch controller's point of view.
interface fetch_ctrl_if #(
  parameter int unsigned REGI_SIZE = 16
) ();
  logic                 imem_req_o;
  logic [REGI_SIZE-1:0] imem_addr_o;
  logic                 imem_ready_i;
  logic                 imem_valid_i;
  logic [REGI_SIZE-1:0] imem_data_i;
  logic                 stall_i;
  logic                 redirect_i;
  logic [REGI_SIZE-1:0] redirect_pc_i;
  logic                 pipe_valid_o;
  logic [REGI_SIZE-1:0] pipe_instr_o;
  logic [REGI_SIZE-1:0] pipe_pc_o;
  logic                 pipe_flush_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ready_i, imem_valid_i, imem_data_i,
    input  stall_i, redirect_i, redirect_pc_i,
    output pipe_valid_o, pipe_instr_o, pipe_pc_o, pipe_flush_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ready_i, imem_valid_i, imem_data_i,
    output stall_i, redirect_i, redirect_pc_i,
    input  pipe_valid_o, pipe_instr_o, pipe_pc_o, pipe_flush_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one imem request in flight and fills the IF/ID slot.
// Optional bubble counter (perf_bubble_o) is enabled with FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int unsigned          REGI_SIZE = 16,
  parameter logic [REGI_SIZE-1:0] RESET_PC  = '0,
  parameter logic [REGI_SIZE-1:0] PC_STEP   = {{(REGI_SIZE-1){1'b0}}, 1'b1}
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_bubble_o
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StBlock} state_e;

  state_e               state_q;
  logic [REGI_SIZE-1:0] pc_q;
  logic                 squash_q;
  logic                 pipe_valid_q;
  logic [REGI_SIZE-1:0] pipe_instr_q;
  logic [REGI_SIZE-1:0] pipe_pc_q;

  logic [REGI_SIZE-1:0] pc_next;
  logic                 slot_free;
  logic                 hold_valid;
  logic                 handshake;
  logic                 resp;

  assign pc_next    = pc_q + PC_STEP;
  assign slot_free  = ~pipe_valid_q | ~bus.stall_i;
  assign hold_valid = pipe_valid_q & bus.stall_i;
  // Gating on slot_free guarantees the slot is empty once the response lands.
  assign bus.imem_req_o = (state_q == StReq) & slot_free;
  assign handshake  = bus.imem_req_o & bus.imem_ready_i;
  assign resp       = (state_q == StWait) & bus.imem_valid_i;

  assign bus.imem_addr_o  = pc_q;
  assign bus.pipe_valid_o = pipe_valid_q;
  assign bus.pipe_instr_o = pipe_instr_q;
  assign bus.pipe_pc_o    = pipe_pc_q;
  assign bus.pipe_flush_o = bus.redirect_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      squash_q     <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_instr_q <= '0;
      pipe_pc_q    <= '0;
    end else if (bus.redirect_i) begin
      pc_q         <= bus.redirect_pc_i;
      pipe_valid_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (resp) begin
            squash_q <= 1'b0;
            state_q  <= StReq;
          end else begin
            squash_q <= 1'b1;
          end
        end
        StReq: begin
          // A request accepted this cycle targets the old path; its response must be dropped.
          if (handshake) begin
            squash_q <= 1'b1;
            state_q  <= StWait;
          end else begin
            state_q  <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end else begin
      pipe_valid_q <= hold_valid;
      unique case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (handshake) begin
            state_q <= StWait;
          end else if (!slot_free) begin
            state_q <= StBlock;
          end
        end
        StWait: begin
          if (resp) begin
            if (squash_q) begin
              squash_q <= 1'b0;
              state_q  <= hold_valid ? StBlock : StReq;
            end else begin
              pipe_valid_q <= 1'b1;
              pipe_instr_q <= bus.imem_data_i;
              pipe_pc_q    <= pc_next;
              pc_q         <= pc_next;
              // Current stall predicts whether the freshly filled slot drains next cycle.
              state_q      <= bus.stall_i ? StBlock : StReq;
            end
          end
        end
        StBlock: begin
          if (slot_free) begin
            state_q <= StReq;
          end
        end
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_q <= '0;
    end else if (!pipe_valid_q && (bubble_q != 32'hFFFF_FFFF)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign perf_bubble_o = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cycle table, reset/wrap sequences, then random traffic
// checked against an instruction-stream scoreboard driven by a latency-randomised memory.
module tb_fetch_ctrl;

  logic clk_i;
  logic rst_i;
  int   total;
  int   bad;

  fetch_ctrl_if #(.REGI_SIZE(16)) bus ();

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_bubble;
`endif

  fetch_ctrl #(
    .REGI_SIZE(16),
    .RESET_PC (16'h0000),
    .PC_STEP  (16'h0001)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_bubble_o (perf_bubble)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [15:0] dat;
    logic        stl;
    logic        rd;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_pv;
    logic [15:0] e_instr;
    logic [15:0] e_ppc;
    logic        e_flush;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rdy, input logic vld, input logic [15:0] dat,
                       input logic stl, input logic rd, input logic [15:0] rpc);
    @(negedge clk_i);
    rst_i             = 1'b0;
    bus.imem_ready_i  = rdy;
    bus.imem_valid_i  = vld;
    bus.imem_data_i   = dat;
    bus.stall_i       = stl;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    #1;
  endtask

  logic        pend;
  logic [15:0] paddr;
  int          lat;
  logic [15:0] exp_pc;
  logic        prev_pv, prev_stall, prev_rd;
  logic [15:0] prev_instr, prev_ppc;
  int          delivered;
  logic        resp_now;

  initial begin
    total = 0;
    bad   = 0;
    bus.imem_ready_i  = 1'b0;
    bus.imem_valid_i  = 1'b0;
    bus.imem_data_i   = '0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    rst_i = 1'b0;
    #1 rst_i = 1'b1;

    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h1000, 16'h0001, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h1001, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'h1000, 16'h0001, 1'b0};
    for (int i = 5; i < 10; i++)
      vecs[i] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h1001, 16'h0002, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h1001, 16'h0002, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h1001, 16'h0002, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 16'h1002, 1'b0, 1'b1, 16'h0030, 1'b0, 16'h0002, 1'b0, 16'h1001, 16'h0002, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 16'h1001, 16'h0002, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0030, 1'b0, 16'h1001, 16'h0002, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h1001, 16'h0002, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h1001, 16'h0002, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 16'h1030, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h1001, 16'h0002, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h1001, 16'h0002, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 16'h1040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0040, 1'b0, 16'h1001, 16'h0002, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b1, 16'h1040, 16'h0041, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0041, 1'b0, 16'h1040, 16'h0041, 1'b0};

    // Reset values while held in reset.
    @(negedge clk_i);
    #1;
    check("rst_req",   {31'b0, bus.imem_req_o}, 32'h0);
    check("rst_addr",  {16'b0, bus.imem_addr_o}, 32'h0);
    check("rst_pv",    {31'b0, bus.pipe_valid_o}, 32'h0);
    check("rst_instr", {16'b0, bus.pipe_instr_o}, 32'h0);
    check("rst_ppc",   {16'b0, bus.pipe_pc_o}, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    check("rst_perf",  perf_bubble, 32'h0);
`endif

    // Cycle table: basic loop, stall/BLOCK, same-cycle redirect, squashed response.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rdy, vecs[i].vld, vecs[i].dat, vecs[i].stl, vecs[i].rd, vecs[i].rpc);
      check($sformatf("v%0d_req", i),   {31'b0, bus.imem_req_o},   {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i),  {16'b0, bus.imem_addr_o},  {16'b0, vecs[i].e_addr});
      check($sformatf("v%0d_pv", i),    {31'b0, bus.pipe_valid_o}, {31'b0, vecs[i].e_pv});
      check($sformatf("v%0d_instr", i), {16'b0, bus.pipe_instr_o}, {16'b0, vecs[i].e_instr});
      check($sformatf("v%0d_ppc", i),   {16'b0, bus.pipe_pc_o},    {16'b0, vecs[i].e_ppc});
      check($sformatf("v%0d_flush", i), {31'b0, bus.pipe_flush_o}, {31'b0, vecs[i].e_flush});
    end

    // Reset asserted while a fetch is outstanding: outputs drop immediately.
    rst_i = 1'b1;
    #1;
    check("midrst_req",  {31'b0, bus.imem_req_o}, 32'h0);
    check("midrst_pv",   {31'b0, bus.pipe_valid_o}, 32'h0);
    check("midrst_addr", {16'b0, bus.imem_addr_o}, 32'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("restart_idle_req", {31'b0, bus.imem_req_o}, 32'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("restart_req",  {31'b0, bus.imem_req_o}, 32'h1);
    check("restart_addr", {16'b0, bus.imem_addr_o}, 32'h0);

    // PC wrap at 0xFFFF.
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFF);
    check("wrap_flush", {31'b0, bus.pipe_flush_o}, 32'h1);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("wrap_req",  {31'b0, bus.imem_req_o}, 32'h1);
    check("wrap_addr", {16'b0, bus.imem_addr_o}, 32'hFFFF);
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("wrap_pv",    {31'b0, bus.pipe_valid_o}, 32'h1);
    check("wrap_instr", {16'b0, bus.pipe_instr_o}, 32'hBEEF);
    check("wrap_ppc",   {16'b0, bus.pipe_pc_o}, 32'h0);
    check("wrap_addr2", {16'b0, bus.imem_addr_o}, 32'h0);

    // Random traffic against the instruction-stream scoreboard.
    pend       = 1'b0;
    paddr      = '0;
    lat        = 0;
    exp_pc     = 16'h0000;
    prev_pv    = 1'b1;
    prev_stall = 1'b0;
    prev_rd    = 1'b0;
    prev_instr = bus.pipe_instr_o;
    prev_ppc   = bus.pipe_pc_o;
    delivered  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      bus.imem_valid_i = 1'b0;
      resp_now = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          bus.imem_valid_i = 1'b1;
          bus.imem_data_i  = mem_f(paddr);
          resp_now = 1'b1;
        end else begin
          lat--;
        end
      end
      bus.stall_i       = ($urandom_range(0, 9) < 3);
      bus.redirect_i    = ($urandom_range(0, 19) == 0);
      bus.redirect_pc_i = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.imem_ready_i  = ($urandom_range(0, 9) < 7);
      #1;
      check("r_flush", {31'b0, bus.pipe_flush_o}, {31'b0, bus.redirect_i});
      if (prev_rd) begin
        check("r_redir_clear", {31'b0, bus.pipe_valid_o}, 32'h0);
      end else if (prev_pv && prev_stall) begin
        check("r_hold_pv",    {31'b0, bus.pipe_valid_o}, 32'h1);
        check("r_hold_instr", {16'b0, bus.pipe_instr_o}, {16'b0, prev_instr});
        check("r_hold_ppc",   {16'b0, bus.pipe_pc_o}, {16'b0, prev_ppc});
      end else if (bus.pipe_valid_o) begin
        check("r_instr", {16'b0, bus.pipe_instr_o}, {16'b0, mem_f(exp_pc)});
        check("r_ppc",   {16'b0, bus.pipe_pc_o}, {16'b0, exp_pc + 16'd1});
        exp_pc = exp_pc + 16'd1;
        delivered++;
      end
      if (resp_now) pend = 1'b0;
      if (bus.imem_req_o && bus.imem_ready_i) begin
        check("r_one_outstanding", {31'b0, pend}, 32'h0);
        if (!bus.redirect_i) check("r_addr", {16'b0, bus.imem_addr_o}, {16'b0, exp_pc});
        pend  = 1'b1;
        paddr = bus.imem_addr_o;
        lat   = $urandom_range(0, 2);
      end
      if (bus.redirect_i) exp_pc = bus.redirect_pc_i;
      prev_pv    = bus.pipe_valid_o;
      prev_stall = bus.stall_i;
      prev_rd    = bus.redirect_i;
      prev_instr = bus.pipe_instr_o;
      prev_ppc   = bus.pipe_pc_o;
    end
    check("r_progress", {31'b0, (delivered >= 100)}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the 16-bit pipeline. Owns the program counter, issues one instruction-memory request at a time, and loads the fetched instruction and its next-PC into the IF/ID pipeline register. It honours stalls from the hazard unit and branch/jump redirects from later stages, squashing any in-flight fetch on a redirect. It sits between the instruction memory and the IF/ID register, and drives that register's data inputs and its clear.

## Interface
- REGI_SIZE, 16, width of PC, address and instruction.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per instruction (word addressing).

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  REGI_SIZE  fetch address (current PC).
- imem_ready_i  in  1  memory accepts the request this cycle (req & ready = handshake).
- imem_valid_i  in  1  response valid.
- imem_data_i  in  REGI_SIZE  response instruction.
- stall_i  in  1  IF/ID must hold; slot not consumed this cycle.
- redirect_i  in  1  taken branch/jump; one-cycle pulse.
- redirect_pc_i  in  REGI_SIZE  redirect target, sampled when redirect_i=1.
- pipe_valid_o  out  1  pipe_instr_o/pipe_pc_o hold a valid instruction.
- pipe_instr_o  out  REGI_SIZE  fetched instruction to IF/ID.
- pipe_pc_o  out  REGI_SIZE  PC of fetched instruction + PC_STEP (next_pc into IF/ID).
- pipe_flush_o  out  1  clear IF/ID; combinational copy of redirect_i.

## Operation
- States: IDLE, REQ, WAIT, BLOCK. Reset: state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, pipe_valid_o=0, pipe_instr_o=0, pipe_pc_o=0, squash flag=0.
- Output slot: one entry (pipe_*). Consumed at any edge where pipe_valid_o=1 and stall_i=0; then pipe_valid_o clears unless refilled on the same edge.
- Slot free condition F = !pipe_valid_o | !stall_i.
- IDLE: always -> REQ next cycle.
- REQ: imem_req_o=1, imem_addr_o=pc. On req&ready -> WAIT; pc unchanged until response.
- WAIT: on imem_valid_i: if squash=0, load pipe_instr_o=imem_data_i, pipe_pc_o=pc+PC_STEP, pipe_valid_o=1, pc<=pc+PC_STEP; if squash=1, drop data, clear squash. Then -> REQ if F holds next cycle, else BLOCK.
- BLOCK: imem_req_o=0; -> REQ when F=1.
- A request is issued only when the slot will be empty at response time; at most one request outstanding.
- Redirect (highest priority, any state): pc<=redirect_pc_i; pipe_valid_o<=0; pipe_flush_o=1 same cycle. In WAIT without same-cycle response: squash<=1, stay WAIT. In WAIT with same-cycle response: response dropped, -> REQ. In REQ (handshake or not): -> REQ with new address next cycle; if handshake fired this cycle, squash<=1 and -> WAIT. In IDLE/BLOCK: -> REQ.
- PC arithmetic modulo 2^REGI_SIZE; 0xFFFF + 1 wraps to 0x0000, no flag.
- stall_i and redirect_i together: redirect wins; slot cleared regardless of stall.

## Timing
- rst_i asserts: outputs reach reset values immediately (async); deassertion is taken synchronously on the next edge.
- Minimum loop: REQ (cycle N, ready=1) -> response cycle N+1 -> pipe_valid_o=1 in N+2, next REQ in N+2. Peak throughput 1 instruction / 2 cycles with 1-cycle memory.
- Redirect in cycle R: pipe_valid_o=0 from R+1; first request to target no earlier than R+1 (R+2 if a squashed response is still pending).
- Reset mid-request: any outstanding response arriving after reset is not tracked; memory must also be reset.

## Configuration
- FETCH_CTRL_PERF_EN: defined -> adds output perf_bubble_o (32 bits, reset 0) counting cycles with pipe_valid_o=0 and rst_i=0, saturating at 0xFFFFFFFF. Undefined -> port and counter absent; no other behaviour changes.

## Test plan
- Reset release, memory ready=1, 1-cycle latency, data=0x1000+addr -> addresses 0,1,2…; pipe_instr_o 0x1000,0x1001; pipe_pc_o 1,2; valid every other cycle.
- stall_i held 5 cycles with slot full -> pipe_* frozen, imem_req_o=0 (BLOCK); on release next request issues one cycle later.
- redirect_i to 0x0040 while WAIT, response 3 cycles later -> that response dropped, pipe_valid_o stays 0, next address 0x0040, pipe_flush_o high for exactly the redirect cycle.
- redirect_i and imem_valid_i same cycle -> instruction discarded, next address = redirect_pc_i.
- PC at 0xFFFF fetch -> pipe_pc_o=0x0000, next address 0x0000.
- rst_i asserted mid-WAIT -> pipe_valid_o=0, imem_req_o=0 immediately; after release fetch restarts at RESET_PC.
